fp32_multiplier: RTL and testbench

- Single-precision IEEE-754 multiplier: sign XOR, exponent add, 24x24 mantissa product, normalize, round-to-nearest-even, special-case handling.
- One registered output stage (latency 1) with a valid qualifier.
- Used as the scalar multiply element inside the FP32 matrix multiplier datapath.

---
 rtl/fp32_multiplier.sv | 169 ++++++++++++++++
 tb/tb_fp32_multiplier.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: binary32 multiply, round-to-nearest-even, one output register.
// Define FP32_MUL_DENORM_EN for subnormal inputs/outputs (default: DAZ/FTZ).
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        exception_flag,
    output logic        overflow_flag,
    output logic        underflow_flag
);

    logic        sa, sb, sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    logic [23:0]        ma, mb;
    logic signed [10:0] xa, xb;
    logic [47:0]        prod, norm, sh;
    logic signed [10:0] exp_n, exp_r;

    logic [22:0] mant;
    logic        guard, sticky, lost, rup, tiny;
    logic [23:0] mr;

    logic [31:0] res_d, res_q;
    logic        exc_d, exc_q, ovf_d, ovf_q, unf_d, unf_q;
    logic        valid_q;

    assign sa = operand_a[31];
    assign sb = operand_b[31];
    assign ea = operand_a[30:23];
    assign eb = operand_b[30:23];
    assign fa = operand_a[22:0];
    assign fb = operand_b[22:0];
    assign sign = sa ^ sb;

    assign a_nan = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf = (eb == 8'hFF) && (fb == 23'd0);

`ifdef FP32_MUL_DENORM_EN
    logic [4:0] lz_a, lz_b;
    logic [5:0] shamt;
    logic       flush;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction

    assign a_zero = (ea == 8'd0) && (fa == 23'd0);
    assign b_zero = (eb == 8'd0) && (fb == 23'd0);
    assign lz_a   = lzc24({1'b0, fa});
    assign lz_b   = lzc24({1'b0, fb});
`else
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
`endif

    // Operand significands with a leading one at bit 23 and signed exponents
    always_comb begin
        ma = {1'b1, fa};
        mb = {1'b1, fb};
        xa = $signed({3'b000, ea});
        xb = $signed({3'b000, eb});
`ifdef FP32_MUL_DENORM_EN
        if (ea == 8'd0) begin
            ma = {1'b0, fa} << lz_a;
            xa = 11'sd1 - $signed({6'b0, lz_a});
        end
        if (eb == 8'd0) begin
            mb = {1'b0, fb} << lz_b;
            xb = 11'sd1 - $signed({6'b0, lz_b});
        end
`endif
    end

    assign prod  = ma * mb;
    assign norm  = prod[47] ? prod : {prod[46:0], 1'b0};
    assign exp_n = xa + xb - 11'sd127 + $signed({10'b0, prod[47]});
    assign tiny  = (exp_n <= 11'sd0);

    always_comb begin
        sh   = norm;
        lost = 1'b0;
`ifdef FP32_MUL_DENORM_EN
        shamt = 6'(11'sd1 - exp_n);
        flush = tiny && (exp_n < -11'sd24);
        if (tiny && !flush) begin
            sh   = norm >> shamt;
            lost = |(norm & ((48'd1 << shamt) - 48'd1));
        end
`endif
        mant   = sh[46:24];
        guard  = sh[23];
        sticky = (|sh[22:0]) | lost;
        rup    = guard & (sticky | mant[0]);
        mr     = {1'b0, mant} + {23'd0, rup};
        exp_r  = exp_n + $signed({10'b0, mr[23]});
    end

    // Special cases first, in priority order, then the finite datapath
    always_comb begin
        res_d = 32'd0;
        exc_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (a_nan || b_nan || (a_zero && b_inf) ||
            (a_inf && b_zero)) begin
            res_d = 32'h7FC0_0000;
            exc_d = 1'b1;
        end else if (a_inf || b_inf) begin
            res_d = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res_d = {sign, 31'd0};
        end else if (tiny) begin
`ifdef FP32_MUL_DENORM_EN
            if (flush) begin
                res_d = {sign, 31'd0};
                unf_d = 1'b1;
            end else begin
                res_d = {sign, 7'd0, mr[23], mr[22:0]};
                unf_d = guard | sticky;
            end
`else
            res_d = {sign, 31'd0};
            unf_d = 1'b1;
`endif
        end else if (exp_r >= 11'sd255) begin
            res_d = {sign, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else begin
            res_d = {sign, exp_r[7:0], mr[22:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
                exc_q <= exc_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign out_valid      = valid_q;
    assign result         = res_q;
    assign exception_flag = exc_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed vectors with hand-computed products and flags.
// Flags are compared as {exception, overflow, underflow}.
module tb_fp32_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic [31:0] result;
    logic        exception_flag;
    logic        overflow_flag;
    logic        underflow_flag;

    int n_cmp = 0;
    int n_bad = 0;

    fp32_multiplier dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .out_valid      (out_valid),
        .result         (result),
        .exception_flag (exception_flag),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mul(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic [2:0] ef);
        @(negedge clk);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, result, er);
        chk({tag, ".flags"},
            {29'd0, exception_flag, overflow_flag, underflow_flag},
            {29'd0, ef});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        #2;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.flags",
            {29'd0, exception_flag, overflow_flag, underflow_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mul("2x2",      32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);
        mul("10x5",     32'h4120_0000, 32'h40A0_0000, 32'h4248_0000, 3'b000);
        mul("-50x0.8",  32'hC248_0000, 32'h3F4C_CCCD, 32'hC220_0000, 3'b000);
        mul("neg.neg",  32'hBF99_999A, 32'hBF19_999A, 32'h3F38_51EC, 3'b000);
        mul("tie.up",   32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 3'b000);
        mul("tie.dn",   32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, 3'b000);
        mul("rnd.cy",   32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000, 3'b000);
        mul("ovf",      32'h7E96_7699, 32'h49F4_23FA, 32'h7F80_0000, 3'b010);
        mul("ovf.neg",  32'hFF7F_FFFF, 32'h3F80_0001, 32'hFF80_0000, 3'b010);
        mul("max.min",  32'h7F7F_FFFF, 32'h0080_0000, 32'h407F_FFFF, 3'b000);
        mul("unf",      32'h0080_0001, 32'h0080_0001, 32'h0000_0000, 3'b001);
        mul("unf.neg",  32'h8080_0001, 32'h0080_0001, 32'h8000_0000, 3'b001);
        mul("0xInf",    32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100);
        mul("nan",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
        mul("negnan",   32'hFF80_0001, 32'h0000_0000, 32'h7FC0_0000, 3'b100);
        mul("inf.fin",  32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000);
        mul("inf.inf",  32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000, 3'b000);
        mul("zero.fin", 32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 3'b000);
`ifdef FP32_MUL_DENORM_EN
        mul("sub.x2",   32'h0040_0000, 32'h4000_0000, 32'h0080_0000, 3'b000);
        mul("sub.tie",  32'h3F00_0000, 32'h0000_0001, 32'h0000_0000, 3'b001);
`else
        mul("sub.x2",   32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 3'b000);
        mul("sub.tie",  32'h3F00_0000, 32'h8000_0001, 32'h8000_0000, 3'b000);
`endif

        mul("hold.pre", 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 3'b000);
        @(negedge clk);
        in_valid  = 1'b0;
        operand_a = 32'h7FC0_0000;
        operand_b = 32'h7FC0_0000;
        @(posedge clk);
        #1;
        chk("idle.valid", {31'd0, out_valid}, 32'd0);
        chk("idle.hold", result, 32'h4040_0000);
        chk("idle.flags",
            {29'd0, exception_flag, overflow_flag, underflow_flag}, 32'd0);

        mul("rst.pre", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.result", result, 32'd0);
        @(negedge clk);
        chk("arst.hold", result, 32'd0);
        rst_n = 1'b1;
        mul("post.rst", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);

        @(negedge clk);
        in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
